// File: rtl/err_eval_sweep_if.sv
// Bus between the sweep engine and the approximate/exact model pair it exercises.
// The slave side is the sweep engine; the master side drives start/abort and model responses.
interface err_eval_sweep_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 14
);
    logic                    start;
    logic                    abort;
    logic [IN_W-1:0]         dut_in;
    logic [OUT_W-1:0]        approx_out;
    logic [OUT_W-1:0]        exact_out;
    logic                    busy;
    logic                    done;
    logic [IN_W:0]           err_count;
    logic [OUT_W-1:0]        max_abs_err;
    logic [IN_W+OUT_W-1:0]   sum_abs_err;

    modport slave (
        input  start, abort, approx_out, exact_out,
        output dut_in, busy, done, err_count, max_abs_err, sum_abs_err
    );

    modport master (
        output start, abort, approx_out, exact_out,
        input  dut_in, busy, done, err_count, max_abs_err, sum_abs_err
    );
endinterface

// File: rtl/err_eval_sweep.sv
// Exhaustive error evaluator: walks every input vector through an approximate and an
// exact model, then reports mismatch count, maximum and summed absolute error.
module err_eval_sweep #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    err_eval_sweep_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [IN_W-1:0] LAST_VEC = '1;

    state_t                  r_state;
    logic [IN_W-1:0]         r_dut_in;
    logic                    r_valid;
    logic                    r_mismatch;
    logic [OUT_W-1:0]        r_diff;
    logic [IN_W:0]           r_err_count;
    logic [OUT_W-1:0]        r_max_abs_err;
    logic [IN_W+OUT_W-1:0]   r_sum_abs_err;
    logic                    r_busy;
    logic                    r_done;

    logic [OUT_W:0]          w_sub;
    logic [OUT_W-1:0]        w_diff;
    logic                    w_mismatch;

    // The extra top bit of the subtraction is the borrow; when set, negate the low bits.
    always_comb begin
        w_sub      = {1'b0, bus.approx_out} - {1'b0, bus.exact_out};
        w_diff     = w_sub[OUT_W] ? (~w_sub[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, 1'b1})
                                  : w_sub[OUT_W-1:0];
        w_mismatch = (bus.approx_out != bus.exact_out);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_dut_in      <= '0;
            r_valid       <= 1'b0;
            r_mismatch    <= 1'b0;
            r_diff        <= '0;
            r_err_count   <= '0;
            r_max_abs_err <= '0;
            r_sum_abs_err <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // Accumulate stage runs whenever the compare stage holds a vector, including
            // on an abort edge, so partial results cover every vector already compared.
            if (r_valid) begin
                r_err_count   <= r_err_count + {{IN_W{1'b0}}, r_mismatch};
                r_sum_abs_err <= r_sum_abs_err + {{IN_W{1'b0}}, r_diff};
                if (r_diff > r_max_abs_err) begin
                    r_max_abs_err <= r_diff;
                end
            end

            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state       <= S_SWEEP;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_dut_in      <= '0;
                        r_valid       <= 1'b0;
                        r_err_count   <= '0;
                        r_max_abs_err <= '0;
                        r_sum_abs_err <= '0;
                    end
                end
                S_SWEEP: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end else begin
                        r_diff     <= w_diff;
                        r_mismatch <= w_mismatch;
                        r_valid    <= 1'b1;
                        r_dut_in   <= r_dut_in + 1'b1;
                        if (r_dut_in == LAST_VEC) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_in      = r_dut_in;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err_count   = r_err_count;
    assign bus.max_abs_err = r_max_abs_err;
    assign bus.sum_abs_err = r_sum_abs_err;
endmodule

// File: tb/tb_err_eval_sweep.sv
// Scenario bench for err_eval_sweep: model responses are generated here, expected
// sweep results are queued at launch and checked when the engine reports done.
module tb_err_eval_sweep;
    localparam int IN_W  = 12;
    localparam int OUT_W = 14;
    localparam int NVEC  = 1 << IN_W;
    localparam int LAT   = NVEC + 1;

    typedef struct {
        logic [IN_W:0]         err;
        logic [OUT_W-1:0]      mx;
        logic [IN_W+OUT_W-1:0] sum;
        int                    lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   mode;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];

    err_eval_sweep_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    err_eval_sweep #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int f_exact(input int m, input int v);
        case (m)
            0, 1:    return v;
            2:       return 0;
            default: return (v * 37 + 11) & 16383;
        endcase
    endfunction

    function automatic int f_approx(input int m, input int v);
        int e;
        e = f_exact(m, v);
        case (m)
            0: return v;
            1: return v + 1;
            2: return (v == NVEC - 1) ? 16383 : 0;
            default: begin
                if (v % 5 == 0)      return (e + 3 * v) & 16383;
                else if (v % 7 == 0) return e ^ 'h2A5;
                else                 return e;
            end
        endcase
    endfunction

    always_comb begin
        bus.exact_out  = OUT_W'(f_exact(mode, int'(bus.dut_in)));
        bus.approx_out = OUT_W'(f_approx(mode, int'(bus.dut_in)));
    end

    // Reference accumulation over vectors first..last, using plain signed arithmetic.
    function automatic exp_t model(input int m, input int first, input int last, input int lat);
        exp_t   r;
        int     err, mx, d;
        longint sum;
        err = 0; mx = 0; sum = 0;
        for (int v = first; v <= last; v++) begin
            d = f_approx(m, v) - f_exact(m, v);
            if (d < 0) d = -d;
            if (d != 0) err++;
            if (d > mx) mx = d;
            sum += d;
        end
        r.err = (IN_W+1)'(err);
        r.mx  = OUT_W'(mx);
        r.sum = (IN_W+OUT_W)'(sum);
        r.lat = lat;
        return r;
    endfunction

    task automatic launch(input bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 3 * NVEC; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done=%b required 00", {bus.busy, bus.done});
        end
        tests_run++;
        if (bus.dut_in !== '0) begin
            tests_failed++;
            $display("FAIL reset_dut_in: got %0d required 0", bus.dut_in);
        end
        tests_run++;
        if (bus.err_count !== '0 || bus.max_abs_err !== '0 || bus.sum_abs_err !== '0) begin
            tests_failed++;
            $display("FAIL reset_results: err=%0d max=%0d sum=%0d required 0", bus.err_count, bus.max_abs_err, bus.sum_abs_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: busy=%b required 0", bus.busy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_sweep(input int m, input string name);
        exp_t e;
        int   lat;
        mode = m;
        exp_q.push_back(model(m, 0, NVEC - 1, LAT));
        launch(1'b0);
        wait_done(lat);
        e = exp_q.pop_front();
        $display("[TB] sweep %s lat=%0d err=%0d max=%0d sum=%0d", name, lat, bus.err_count, bus.max_abs_err, bus.sum_abs_err);
        tests_run++;
        if (lat !== e.lat) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
        end
        tests_run++;
        if (bus.err_count !== e.err) begin
            tests_failed++;
            $display("FAIL %s_err_count: got %0d required %0d", name, bus.err_count, e.err);
        end
        tests_run++;
        if (bus.max_abs_err !== e.mx) begin
            tests_failed++;
            $display("FAIL %s_max_abs_err: got %0d required %0d", name, bus.max_abs_err, e.mx);
        end
        tests_run++;
        if (bus.sum_abs_err !== e.sum) begin
            tests_failed++;
            $display("FAIL %s_sum_abs_err: got %0d required %0d", name, bus.sum_abs_err, e.sum);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.dut_in !== '0) begin
            tests_failed++;
            $display("FAIL %s_end_state: busy=%b dut_in=%0d required 0/0", name, bus.busy, bus.dut_in);
        end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (bus.done !== 1'b1 || bus.err_count !== e.err || bus.sum_abs_err !== e.sum) begin
            tests_failed++;
            $display("FAIL %s_done_hold: done=%b err=%0d sum=%0d required 1/%0d/%0d", name, bus.done, bus.err_count, bus.sum_abs_err, e.err, e.sum);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        mode = 3;
        exp_q.push_back(model(3, 0, 98, 0));
        launch(1'b0);
        repeat (99) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        e = exp_q.pop_front();
        $display("[TB] abort err=%0d max=%0d sum=%0d dut_in=%0d", bus.err_count, bus.max_abs_err, bus.sum_abs_err, bus.dut_in);
        tests_run++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_flags: busy/done=%b required 00", {bus.busy, bus.done});
        end
        tests_run++;
        if (bus.err_count !== e.err || bus.max_abs_err !== e.mx || bus.sum_abs_err !== e.sum) begin
            tests_failed++;
            $display("FAIL abort_partial: err=%0d max=%0d sum=%0d required %0d/%0d/%0d", bus.err_count, bus.max_abs_err, bus.sum_abs_err, e.err, e.mx, e.sum);
        end
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (bus.dut_in !== IN_W'(99) || bus.err_count !== e.err || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_frozen: dut_in=%0d err=%0d done=%b required 99/%0d/0", bus.dut_in, bus.err_count, bus.done, e.err);
        end
    endtask

    task automatic test_reset_mid();
        bit reached;
        mode = 3;
        reached = 1'b0;
        launch(1'b0);
        for (int n = 0; n < 3 * NVEC; n++) begin
            @(posedge clk);
            #1;
            if (bus.dut_in == IN_W'(2000)) begin
                reached = 1'b1;
                break;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] reset mid-sweep dut_in=%0d busy=%b", bus.dut_in, bus.busy);
        tests_run++;
        if (!reached || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_in !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_flags: reached=%b busy=%b done=%b dut_in=%0d required 1/0/0/0", reached, bus.busy, bus.done, bus.dut_in);
        end
        tests_run++;
        if (bus.err_count !== '0 || bus.max_abs_err !== '0 || bus.sum_abs_err !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_results: err=%0d max=%0d sum=%0d required 0", bus.err_count, bus.max_abs_err, bus.sum_abs_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.dut_in !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_resume: busy=%b dut_in=%0d required 0/0", bus.busy, bus.dut_in);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        mode = 1;
        exp_q.push_back(model(1, 0, NVEC - 1, LAT));
        exp_q.push_back(model(1, 0, NVEC - 1, LAT));
        launch(1'b1);
        wait_done(lat);
        e = exp_q.pop_front();
        $display("[TB] back_to_back first lat=%0d err=%0d sum=%0d", lat, bus.err_count, bus.sum_abs_err);
        tests_run++;
        if (lat !== e.lat || bus.err_count !== e.err || bus.sum_abs_err !== e.sum) begin
            tests_failed++;
            $display("FAIL b2b_first: lat=%0d err=%0d sum=%0d required %0d/%0d/%0d", lat, bus.err_count, bus.sum_abs_err, e.lat, e.err, e.sum);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.dut_in !== '0 ||
            bus.err_count !== '0 || bus.max_abs_err !== '0 || bus.sum_abs_err !== '0) begin
            tests_failed++;
            $display("FAIL b2b_restart: busy=%b done=%b dut_in=%0d err=%0d max=%0d sum=%0d required 1/0/0/0/0/0", bus.busy, bus.done, bus.dut_in, bus.err_count, bus.max_abs_err, bus.sum_abs_err);
        end
        wait_done(lat);
        bus.start = 1'b0;
        e = exp_q.pop_front();
        $display("[TB] back_to_back second lat=%0d err=%0d max=%0d sum=%0d", lat, bus.err_count, bus.max_abs_err, bus.sum_abs_err);
        tests_run++;
        if (lat !== e.lat || bus.err_count !== e.err || bus.max_abs_err !== e.mx || bus.sum_abs_err !== e.sum) begin
            tests_failed++;
            $display("FAIL b2b_second: lat=%0d err=%0d max=%0d sum=%0d required %0d/%0d/%0d/%0d", lat, bus.err_count, bus.max_abs_err, bus.sum_abs_err, e.lat, e.err, e.mx, e.sum);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done_hold: done=%b busy=%b required 1/0", bus.done, bus.busy);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mode         = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        test_reset();
        test_sweep(0, "golden");
        test_sweep(1, "plus_one");
        test_sweep(2, "last_vector");
        test_sweep(3, "pattern");
        test_abort();
        test_reset_mid();
        test_sweep(3, "after_reset");
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
